// File: rtl/delta_sigma_pkg.sv
// ----------------------------------------------------------------------------
// delta_sigma_pkg
// Shared types and sizing helpers for the multi-channel delta-sigma DAC.
//   ds_mode_e      : modulator order select (DS_ORDER1 / DS_ORDER2)
//   ds_int_width() : width of the signed 2nd-order integrators for a sample width
//   ds_sat_limit() : magnitude at which the 2nd-order integrators saturate
// ----------------------------------------------------------------------------
package delta_sigma_pkg;

  typedef enum logic {
    DS_ORDER1 = 1'b0,
    DS_ORDER2 = 1'b1
  } ds_mode_e;

  function automatic int unsigned ds_int_width(input int unsigned data_w);
    return data_w + 3;
  endfunction

  function automatic int ds_sat_limit(input int unsigned data_w);
    return 1 << (data_w + 1);
  endfunction

endpackage

// File: rtl/ds_mod_channel.sv
// ----------------------------------------------------------------------------
// ds_mod_channel
// One delta-sigma modulator, selectable 1st or 2nd order.
// Ports:
//   i_clk     : system clock
//   i_rst_n   : synchronous active-low reset
//   i_en      : enable; when low the output is forced 0 and state holds
//   i_clear   : clear all integrators and the output bit this edge
//   i_mode    : modulator order
//   i_sample  : unsigned input sample, full scale 2^DATA_W
//   o_bit     : registered 1-bit PDM output
// ----------------------------------------------------------------------------
module ds_mod_channel
  import delta_sigma_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clear,
  input  ds_mode_e          i_mode,
  input  logic [DATA_W-1:0] i_sample,
  output logic              o_bit
);

  localparam int unsigned IW = ds_int_width(DATA_W);
  // One extra bit so sums can be formed before saturation without wrapping.
  localparam int unsigned SW = IW + 1;

  typedef logic signed [SW-1:0] wide_t;

  localparam wide_t LIM = wide_t'(ds_sat_limit(DATA_W));
  localparam wide_t FS  = wide_t'(1 << DATA_W);

  function automatic wide_t sat(input wide_t v);
    if (v > LIM)       return LIM;
    else if (v < -LIM) return -LIM;
    else               return v;
  endfunction

  // 1st-order accumulator keeps only the low DATA_W bits; the carry
  // out of the sum is the output bit itself.
  logic [DATA_W-1:0]    r_acc;
  logic signed [IW-1:0] r_i1;
  logic signed [IW-1:0] r_i2;
  logic                 r_out;

  logic [DATA_W:0] w_acc_n;
  wide_t           w_fb;
  wide_t           w_i1_n;
  wide_t           w_i2_n;
  logic            w_bit2;

  always_comb begin
    w_acc_n = {1'b0, r_acc} + {1'b0, i_sample};
    w_fb    = r_out ? FS : '0;
    w_i1_n  = sat(wide_t'(r_i1) + wide_t'({1'b0, i_sample}) - w_fb);
    w_i2_n  = sat(wide_t'(r_i2) + w_i1_n - w_fb);
    w_bit2  = !w_i2_n[SW-1] && (w_i2_n != '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_acc <= '0;
      r_i1  <= '0;
      r_i2  <= '0;
      r_out <= 1'b0;
    end else if (!i_en) begin
      r_out <= 1'b0;
    end else if (i_mode == DS_ORDER2) begin
      r_i1  <= w_i1_n[IW-1:0];
      r_i2  <= w_i2_n[IW-1:0];
      r_out <= w_bit2;
    end else begin
      r_acc <= w_acc_n[DATA_W-1:0];
      r_out <= w_acc_n[DATA_W];
    end
  end

  assign o_bit = r_out;

endmodule

// File: rtl/delta_sigma_dac_mc.sv
// ----------------------------------------------------------------------------
// delta_sigma_dac_mc
// Multi-channel delta-sigma DAC with double-buffered sample loading.
// Writes land in a shadow bank; a commit pulse copies every shadow sample and
// the per-channel order select into the active bank in one edge.
// Ports:
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   en        : global modulator enable
//   wr_valid  : sample write request
//   wr_ready  : write accepted when wr_valid & wr_ready
//   wr_chan   : target channel (out-of-range indices are accepted and dropped)
//   wr_data   : sample value
//   commit    : copy all shadow samples/modes to active
//   mode_in   : per-channel order applied on commit (0=1st, 1=2nd)
//   dac_out   : registered 1-bit PDM outputs
// ----------------------------------------------------------------------------
module delta_sigma_dac_mc
  import delta_sigma_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned DATA_W   = 8,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                commit,
  input  logic [CHANNELS-1:0] mode_in,
  output logic [CHANNELS-1:0] dac_out
);

  logic [DATA_W-1:0] r_shadow [CHANNELS];
  logic [DATA_W-1:0] r_active [CHANNELS];
  ds_mode_e          r_mode   [CHANNELS];
  logic              r_wr_ready;

  logic                w_wr_acc;
  logic [CHANNELS-1:0] w_wr_hit;
  logic [CHANNELS-1:0] w_clear;
  logic [DATA_W-1:0]   w_commit_val [CHANNELS];

  assign w_wr_acc = wr_valid & r_wr_ready;
  assign wr_ready = r_wr_ready;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_wr_hit[g] = w_wr_acc && (wr_chan == CH_W'(g));
    // A write in the commit cycle bypasses the shadow straight into active.
    assign w_commit_val[g] = w_wr_hit[g] ? wr_data : r_shadow[g];
    // Clear coincides with the commit edge so the first new-mode bit
    // starts from zeroed integrators.
    assign w_clear[g] = commit && (ds_mode_e'(mode_in[g]) != r_mode[g]);

    ds_mod_channel #(
      .DATA_W(DATA_W)
    ) u_ch (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (en),
      .i_clear (w_clear[g]),
      .i_mode  (r_mode[g]),
      .i_sample(r_active[g]),
      .o_bit   (dac_out[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ready <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
        r_mode[i]   <= DS_ORDER1;
      end
    end else begin
      r_wr_ready <= !commit;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (w_wr_hit[i]) r_shadow[i] <= wr_data;
        if (commit) begin
          r_active[i] <= w_commit_val[i];
          r_mode[i]   <= ds_mode_e'(mode_in[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_delta_sigma_dac_mc.sv
// ----------------------------------------------------------------------------
// tb_delta_sigma_dac_mc
// Directed stimulus pushes expected observations into a queue; an independent
// monitor pops each one, samples the DUT on falling edges and compares.
// Item kinds:
//   K_ONES : count cycles with a 1 on a channel (-1 = any channel) in [lo,hi]
//   K_SEQ  : exact bit sequence (bit i = sample i) on a channel (-2 = wr_ready)
// Five channels are used so that wr_chan = 7 is a genuine out-of-range index.
// ----------------------------------------------------------------------------
module tb_delta_sigma_dac_mc;

  localparam int CH = 5;
  localparam int DW = 8;
  localparam int CW = 3;

  localparam int K_ONES = 0;
  localparam int K_SEQ  = 1;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_chan;
  logic [DW-1:0] wr_data;
  logic          commit;
  logic [CH-1:0] mode_in;
  logic [CH-1:0] dac_out;

  delta_sigma_dac_mc #(
    .CHANNELS(CH),
    .DATA_W  (DW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_chan (wr_chan),
    .wr_data (wr_data),
    .commit  (commit),
    .mode_in (mode_in),
    .dac_out (dac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    kind;
    int    chan;
    int    skip;
    int    cycles;
    int    lo;
    int    hi;
  } item_t;

  item_t q[$];
  bit    busy = 1'b0;
  int    n_cmp = 0;
  int    n_err = 0;

  // ---------------- monitor ----------------
  initial begin : monitor
    item_t it;
    int    cnt;
    int    pat;
    logic  b;
    bit    ok;
    forever begin
      wait (q.size() > 0);
      it   = q.pop_front();
      busy = 1'b1;
      repeat (it.skip) @(negedge clk);
      cnt = 0;
      pat = 0;
      for (int i = 0; i < it.cycles; i++) begin
        @(negedge clk);
        if (it.chan == -2)      b = wr_ready;
        else if (it.chan == -1) b = |dac_out;
        else                    b = dac_out[it.chan];
        cnt += int'(b);
        pat |= int'(b) << i;
      end
      n_cmp++;
      if (it.kind == K_ONES) ok = (cnt >= it.lo) && (cnt <= it.hi);
      else                   ok = (pat == it.lo);
      if (!ok) begin
        n_err++;
        if (it.kind == K_ONES)
          $display("FAIL %s: ones=%0d required %0d..%0d", it.name, cnt, it.lo, it.hi);
        else
          $display("FAIL %s: seq=%b required %b", it.name, pat[15:0], it.lo[15:0]);
      end
      busy = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input string nm, input int kind, input int ch,
                      input int skip, input int cyc, input int lo, input int hi);
    item_t it;
    it.name = nm; it.kind = kind; it.chan = ch; it.skip = skip;
    it.cycles = cyc; it.lo = lo; it.hi = hi;
    q.push_back(it);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: monitor busy after 3000 cycles, required idle");
    end
  endtask

  task automatic wr(input int ch, input int d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_chan  = CW'(ch);
    wr_data  = DW'(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Commit (optionally with a same-cycle write); the check item, if any, is
  // queued in the cycle commit is asserted so skip=1 aligns to edge t+1.
  task automatic do_commit(input logic [CH-1:0] m, input bit wv, input int wch,
                           input int wd, input string nm, input int kind,
                           input int ch, input int skip, input int cyc,
                           input int lo, input int hi);
    @(negedge clk);
    commit  = 1'b1;
    mode_in = m;
    if (wv) begin
      wr_valid = 1'b1;
      wr_chan  = CW'(wch);
      wr_data  = DW'(wd);
    end
    if (cyc > 0) push(nm, kind, ch, skip, cyc, lo, hi);
    @(negedge clk);
    commit   = 1'b0;
    wr_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    rst_n = 1'b0; en = 1'b1; wr_valid = 1'b0; wr_chan = '0;
    wr_data = '0; commit = 1'b0; mode_in = '0;

    // Reset held, then released.
    repeat (3) @(negedge clk);
    push("rst_ready", K_SEQ, -2, 0, 2, 0, 0);
    push("rst_dac", K_ONES, -1, 0, 2, 0, 0);
    wait_idle();
    rst_n = 1'b1;
    push("rel_ready", K_SEQ, -2, 0, 3, 7, 0);
    wait_idle();

    // Channel 0, 1st order.
    wr(0, 8'h40);
    do_commit(5'b00000, 0, 0, 0, "ch0_x40", K_ONES, 0, 1, 256, 64, 64);
    wait_idle();
    wr(0, 8'h00);
    do_commit(5'b00000, 0, 0, 0, "ch0_x00", K_ONES, 0, 1, 256, 0, 0);
    wait_idle();
    wr(0, 8'hFF);
    do_commit(5'b00000, 0, 0, 0, "ch0_xff", K_ONES, 0, 1, 256, 255, 255);
    wait_idle();

    // Channel 1, 2nd order, each window from freshly cleared integrators.
    wr(1, 8'h80);
    do_commit(5'b00010, 0, 0, 0, "ch1_x80", K_ONES, 1, 1, 256, 126, 130);
    wait_idle();
    do_commit(5'b00000, 0, 0, 0, "", K_ONES, 0, 0, 0, 0, 0);
    wr(1, 8'h10);
    do_commit(5'b00010, 0, 0, 0, "ch1_x10", K_ONES, 1, 1, 256, 14, 18);
    wait_idle();
    do_commit(5'b00000, 0, 0, 0, "", K_ONES, 0, 0, 0, 0, 0);
    wr(1, 8'h00);
    do_commit(5'b00010, 0, 0, 0, "ch1_x00", K_ONES, 1, 1, 256, 0, 0);
    wait_idle();

    // Shadow writes without commit leave the outputs alone.
    wr(0, 8'h20); wr(1, 8'h80); wr(2, 8'h60); wr(3, 8'hA0);
    push("hold_ch0", K_ONES, 0, 0, 256, 255, 255);
    push("hold_ch2", K_ONES, 2, 0, 256, 0, 0);
    wait_idle();

    // Commit: wr_ready low for exactly the cycle after, all channels updated.
    do_commit(5'b00010, 0, 0, 0, "commit_ready", K_SEQ, -2, 0, 3, 6, 0);
    push("new_ch0", K_ONES, 0, 0, 256, 32, 32);
    push("new_ch2", K_ONES, 2, 0, 256, 96, 96);
    push("new_ch3", K_ONES, 3, 0, 256, 160, 160);
    wait_idle();

    // Same-cycle write + commit bypasses into active.
    do_commit(5'b00010, 1, 2, 8'hC0, "bypass_ch2", K_ONES, 2, 1, 256, 192, 192);
    wait_idle();

    // Out-of-range channel write is accepted and dropped.
    wr(7, 8'h33);
    do_commit(5'b00010, 0, 0, 0, "", K_ONES, 0, 0, 0, 0, 0);
    push("oor_ch0", K_ONES, 0, 0, 256, 32, 32);
    push("oor_ch2", K_ONES, 2, 0, 256, 192, 192);
    push("oor_ch3", K_ONES, 3, 0, 256, 160, 160);
    push("oor_ch4", K_ONES, 4, 0, 256, 0, 0);
    wait_idle();

    // Clear ch3 via two mode toggles; x=0xA0 from zero gives 0,1,0,1,1,0,1,1.
    do_commit(5'b01010, 0, 0, 0, "", K_ONES, 0, 0, 0, 0, 0);
    do_commit(5'b00010, 0, 0, 0, "en_pre", K_SEQ, 3, 1, 4, 4'b1010, 0);
    wait_idle();
    en = 1'b0;
    push("en_off", K_ONES, -1, 0, 20, 0, 0);
    wait_idle();
    en = 1'b1;
    push("en_resume", K_SEQ, 3, 0, 4, 4'b1101, 0);
    wait_idle();

    // Reset mid-stream clears active and shadow banks.
    rst_n = 1'b0;
    push("rst_mid_ready", K_SEQ, -2, 0, 2, 0, 0);
    push("rst_mid_dac", K_ONES, -1, 0, 2, 0, 0);
    wait_idle();
    rst_n = 1'b1;
    push("post_rst", K_ONES, -1, 0, 256, 0, 0);
    wait_idle();
    do_commit(5'b00000, 0, 0, 0, "post_rst_commit", K_ONES, -1, 1, 256, 0, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
